// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: owner-state encoding and arbitration defaults for the
// single-ported memory arbiter.
package mem_arbiter_pkg;

  // Default bound on consecutive contested cycles that fetch may lose.
  localparam int STARVE_MAX_DEFAULT = 3;

  // Which side owns the read data returning from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_DATA_RD = 2'd1,
    OWN_INST_RD = 2'd2
  } owner_e;

  // Counter width able to hold 0..max_v; never narrower than one bit.
  function automatic int cnt_width(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Starvation counter: counts consecutive contested cycles lost by fetch and
// flags when fetch must be given the next contested slot.
module mem_arbiter_starve_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic data_won,   // contested cycle resolved in favour of data
  input  logic fetch_won,  // any fetch grant
  output logic at_max
);

  localparam int W = cnt_width(STARVE_MAX);
  localparam logic [W-1:0] MAX_C = W'(STARVE_MAX);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;
  logic         at_max_s;

  // Saturating compare: fetch wins the contested slot once the bound is hit.
  always_comb begin
    at_max_s  = (cnt_r == MAX_C);
    cnt_nxt_s = cnt_r;
    if (fetch_won) begin
      cnt_nxt_s = {W{1'b0}};
    end else if (data_won && !at_max_s) begin
      cnt_nxt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign at_max = at_max_s;

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter in front of one synchronous memory port. Data (MEM stage)
// normally wins; fetch is guaranteed a slot after STARVE_MAX contested losses.
// Grants are combinational; read data returns one cycle later to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:2] d_addr,
  input  logic [31:0] d_din,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_dout,
  input  logic        i_req,
  input  logic [31:2] i_addr,
  output logic        i_gnt,
  output logic        i_valid,
  output logic [31:0] i_dout,
  output logic [31:2] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [31:0] mem_dout,
  output logic        stall
);

  owner_e owner_r;
  owner_e owner_nxt_s;

  logic d_gnt_s;
  logic i_gnt_s;
  logic data_won_s;
  logic at_max_s;

  mem_arbiter_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .data_won (data_won_s),
    .fetch_won(i_gnt_s),
    .at_max   (at_max_s)
  );

  // Grant decision and shared-port steering for the current cycle.
  always_comb begin
    i_gnt_s    = i_req & (~d_req | at_max_s);
    d_gnt_s    = d_req & ~i_gnt_s;
    data_won_s = d_gnt_s & i_req;
    mem_en     = d_gnt_s | i_gnt_s;
    mem_we     = d_gnt_s & d_we;
    if (d_gnt_s) begin
      mem_addr = d_addr;
      mem_din  = d_din;
    end else if (i_gnt_s) begin
      mem_addr = i_addr;
      mem_din  = 32'h0000_0000;
    end else begin
      mem_addr = 30'h0000_0000;
      mem_din  = 32'h0000_0000;
    end
  end

  // Next owner: whichever side issued a read this cycle; writes return nothing.
  always_comb begin
    owner_nxt_s = OWN_NONE;
    if (d_gnt_s && !d_we) begin
      owner_nxt_s = OWN_DATA_RD;
    end else if (i_gnt_s) begin
      owner_nxt_s = OWN_INST_RD;
    end else begin
      owner_nxt_s = OWN_NONE;
    end
  end

  // Owner register; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_nxt_s;
    end
  end

  // Route returning memory data to the owner; non-owners see zero.
  always_comb begin
    d_valid = 1'b0;
    d_dout  = 32'h0000_0000;
    i_valid = 1'b0;
    i_dout  = 32'h0000_0000;
    case (owner_r)
      OWN_DATA_RD: begin
        d_valid = 1'b1;
        d_dout  = mem_dout;
      end
      OWN_INST_RD: begin
        i_valid = 1'b1;
        i_dout  = mem_dout;
      end
      default: begin
        d_valid = 1'b0;
        i_valid = 1'b0;
      end
    endcase
  end

  assign d_gnt = d_gnt_s;
  assign i_gnt = i_gnt_s;
  assign stall = i_req & ~i_gnt_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:2] d_addr = '0;
  logic [31:0] d_din = '0;
  logic        d_gnt, d_valid;
  logic [31:0] d_dout;
  logic        i_req = 1'b0;
  logic [31:2] i_addr = '0;
  logic        i_gnt, i_valid;
  logic [31:0] i_dout;
  logic [31:2] mem_addr;
  logic [31:0] mem_din;
  logic        mem_en, mem_we;
  logic [31:0] mem_dout = '0;
  logic        stall;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_dout(d_dout),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt), .i_valid(i_valid), .i_dout(i_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_we(mem_we),
    .mem_dout(mem_dout), .stall(stall)
  );

  // Environment: 256-word synchronous memory attached to the shared port.
  logic [31:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr[9:2]] <= mem_din;
      else        mem_dout <= env_mem[mem_addr[9:2]];
    end
  end

  // Reference model state: memory image, fetch-loss count, pending return.
  logic [31:0] ref_mem [256];
  int          m_losses = 0;
  int          m_pend = 0;       // 0 none, 1 data read, 2 fetch read
  logic [7:0]  m_paddr = '0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus plus a full check of every output.
  task automatic cyc(input logic r, input logic dq, input logic dw,
                     input logic [31:2] da, input logic [31:0] dd,
                     input logic iq, input logic [31:2] ia);
    logic        e_dg, e_ig;
    logic [31:2] e_addr;
    logic [31:0] e_din, e_rd;
    @(negedge clk);
    rst = r; d_req = dq; d_we = dw; d_addr = da; d_din = dd;
    i_req = iq; i_addr = ia;
    #1;
    if (r) begin
      m_losses = 0;
      m_pend = 0;
    end
    // Fetch gets the port when alone, or when it has already lost SMAX times.
    e_ig = iq && (!dq || m_losses >= SMAX);
    e_dg = dq && !e_ig;
    e_addr = e_dg ? da : (e_ig ? ia : 30'd0);
    e_din  = e_dg ? dd : 32'd0;
    e_rd   = ref_mem[m_paddr];
    chk("d_gnt",   {31'd0, d_gnt},   {31'd0, e_dg});
    chk("i_gnt",   {31'd0, i_gnt},   {31'd0, e_ig});
    chk("mem_en",  {31'd0, mem_en},  {31'd0, e_dg | e_ig});
    chk("mem_we",  {31'd0, mem_we},  {31'd0, e_dg & dw});
    chk("mem_addr", {2'd0, mem_addr}, {2'd0, e_addr});
    chk("mem_din", mem_din, e_din);
    chk("stall",   {31'd0, stall},   {31'd0, iq & ~e_ig});
    chk("d_valid", {31'd0, d_valid}, {31'd0, m_pend == 1});
    chk("d_dout",  d_dout, (m_pend == 1) ? e_rd : 32'd0);
    chk("i_valid", {31'd0, i_valid}, {31'd0, m_pend == 2});
    chk("i_dout",  i_dout, (m_pend == 2) ? e_rd : 32'd0);
    if (!r) begin
      if (e_ig) m_losses = 0;
      else if (e_dg && iq) m_losses++;
      m_pend = 0;
      if (e_dg && dw) ref_mem[da[9:2]] = dd;
      else if (e_dg) begin m_pend = 1; m_paddr = da[9:2]; end
      else if (e_ig) begin m_pend = 2; m_paddr = ia[9:2]; end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    env_mem[16] = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;

    // Reset state.
    cyc(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);
    cyc(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);

    // Data read of 0x10, returned the next cycle.
    cyc(1'b0, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0, 30'd0);
    cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);
    chk("deadbeef_ref", ref_mem[16], 32'hDEAD_BEEF);

    // Continuous contention: D,D,D,I repeating.
    for (int k = 0; k < 9; k++)
      cyc(1'b0, 1'b1, 1'b0, 30'(k + 1), 32'd0, 1'b1, 30'(k + 40));
    cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);

    // Write 0x20, then fetch it back.
    cyc(1'b0, 1'b1, 1'b1, 30'h20, 32'h1234_5678, 1'b0, 30'd0);
    cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 30'h20);
    cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);
    chk("wr_then_fetch_ref", ref_mem[32], 32'h1234_5678);

    // Fetch-only stream, back to back.
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 30'(k));
    cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);

    // Reset right after a data read grant; then immediate post-reset grant.
    cyc(1'b0, 1'b1, 1'b0, 30'h10, 32'd0, 1'b1, 30'd3);
    cyc(1'b0, 1'b1, 1'b0, 30'h11, 32'd0, 1'b1, 30'd3);
    cyc(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);
    cyc(1'b0, 1'b1, 1'b0, 30'h5, 32'd0, 1'b0, 30'd0);
    // Counter must restart from zero: three data wins before fetch.
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 1'b1, 1'b0, 30'(k), 32'd0, 1'b1, 30'(k + 8));
    cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);

    // Random traffic over a small address window so writes get read back.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
          30'($urandom_range(0, 15)),
          32'($urandom),
          ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
          30'($urandom_range(0, 15)));
    end
    cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 30'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive contested cycles in which fetch may lose to data.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port d_req, input, 1 bit: data-side (MEM stage) access request.
REQ-005 SHALL have port d_we, input, 1 bit: data-side write enable, qualified by d_req.
REQ-006 SHALL have port d_addr, input, [31:2]: data-side word address.
REQ-007 SHALL have port d_din, input, 32 bits: data-side write data.
REQ-008 SHALL have port d_gnt, output, 1 bit: data access issued this cycle.
REQ-009 SHALL have port d_valid, output, 1 bit: d_dout holds read data.
REQ-010 SHALL have port d_dout, output, 32 bits: data-side read data.
REQ-011 SHALL have port i_req, input, 1 bit: fetch-side read request.
REQ-012 SHALL have port i_addr, input, [31:2]: fetch word address.
REQ-013 SHALL have port i_gnt, output, 1 bit: fetch read issued this cycle.
REQ-014 SHALL have port i_valid, output, 1 bit: i_dout holds the fetched instruction.
REQ-015 SHALL have port i_dout, output, 32 bits: fetched instruction.
REQ-016 SHALL have ports mem_addr [31:2], mem_din [32], mem_en [1], mem_we [1], all outputs: the single shared synchronous memory port.
REQ-017 SHALL have port mem_dout, input, 32 bits: memory read data, valid one cycle after mem_en with mem_we=0.
REQ-018 SHALL have port stall, output, 1 bit: i_req & ~i_gnt, used by the pipeline to hold IF.

Function
REQ-019 Grant SHALL be combinational in the request cycle; at most one of d_gnt and i_gnt is high in any cycle.
REQ-020 Only d_req: d_gnt=1. Only i_req: i_gnt=1. Neither: both 0, mem_en=0.
REQ-021 Both requesting: data wins while starve_cnt < STARVE_MAX, with starve_cnt incremented; fetch wins when starve_cnt == STARVE_MAX, with starve_cnt cleared.
REQ-022 starve_cnt SHALL clear on any fetch grant, and SHALL hold on uncontested data grants and idle cycles; it is clog2(STARVE_MAX+1) bits wide and never exceeds STARVE_MAX.
REQ-023 mem_en=d_gnt|i_gnt; mem_addr/mem_din/mem_we SHALL come from the granted side; mem_we=d_gnt&d_we; fetch never writes; when idle, mem_addr and mem_din are 0.
REQ-024 Owner FSM states: NONE, DATA_RD, INST_RD. On each clock the next state is DATA_RD if d_gnt&~d_we, INST_RD if i_gnt, else NONE; writes give NONE.
REQ-025 Read latency: exactly 1 cycle; in DATA_RD, d_valid=1 and d_dout=mem_dout; in INST_RD, i_valid=1 and i_dout=mem_dout; otherwise the valid is 0 and the data output is 0.
REQ-026 A new grant SHALL be issued in the same cycle a previous read returns (back-to-back, full throughput).
REQ-027 A write SHALL complete in the grant cycle; no response strobe.

Reset
REQ-028 While rst=1: owner=NONE, starve_cnt=0, d_valid=i_valid=0, d_dout=i_dout=0; a read in flight at reset is discarded with no valid produced.
REQ-029 Grants SHALL follow requests combinationally in the first cycle after rst deasserts.

Structure
REQ-030 Owner-state encoding (NONE/DATA_RD/INST_RD) and STARVE_MAX default SHALL live in the shared CPU package.
REQ-031 A sub-module starve_ctr (saturating compare/clear counter) is natural; the rest is flat.

Verification
REQ-032 d_req=1, d_we=0, d_addr=0x10 with memory word 0x10=0xDEADBEEF -> d_gnt same cycle, next cycle d_valid=1 and d_dout=0xDEADBEEF, i_valid=0.
REQ-033 Both sides requesting continuously (STARVE_MAX=3) -> grant pattern D,D,D,I repeating; stall=1 on D cycles.
REQ-034 d_we=1, d_addr=0x20, d_din=0x12345678, then i_req to 0x20 -> mem_we pulse one cycle, then i_dout=0x12345678 with no d_valid.
REQ-035 Fetch-only stream to addresses 0,1,2 -> i_valid on three consecutive cycles with matching data, stall=0 throughout.
REQ-036 rst asserted in the cycle after a data read grant -> no d_valid, starve_cnt=0, outputs zero; first post-reset request granted immediately.
